simt_operand_collector: RTL and testbench
=========================================

# simt_operand_collector

Sequential operand collector that sits between warp issue and the combinational integer ALU. It accepts one issued instruction at a time and reads its source registers from a single-read-port, one-cycle-latency vector register file, one operand per cycle. It then presents the complete operand bundle (op, warp, imm, rs1/rs2/rs3, src_pred) to the ALU under a valid/ready handshake.

## Interface
Parameters:
- WARP_SIZE, 32, lanes per warp; width of operand vectors and predicate masks
- REG_W, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  instruction offered
- issue_ready  out  1  collector can accept an instruction
- issue_op  in  8  opcode (opcode_e encoding); forwarded unmodified
- issue_warp  in  5  warp id
- issue_imm  in  32  immediate; forwarded unmodified
- issue_src1 / issue_src2 / issue_src3  in  REG_W each  source register indices
- issue_nsrc  in  2  number of sources to read, 0..3; read in order src1, src2, src3
- issue_pred  in  WARP_SIZE  per-lane select predicate for SELP
- rf_rd_en  out  1  register file read strobe
- rf_rd_warp  out  5  read warp id
- rf_rd_reg  out  REG_W  read register index
- rf_rd_data  in  WARP_SIZE×32  read data, valid the cycle after rf_rd_en
- alu_valid  out  1  operand bundle valid
- alu_ready  in  1  ALU stage accepts bundle
- alu_op  out  8, alu_warp  out  5, alu_imm  out  32  latched issue fields
- alu_rs1 / alu_rs2 / alu_rs3  out  WARP_SIZE×32 each  collected operands
- alu_src_pred  out  WARP_SIZE  latched issue_pred
- busy  out  1  high in any state except IDLE

## Operation
- States: IDLE, READ, DRAIN, DISPATCH.
- IDLE: issue_ready=1. Handshake (issue_valid & issue_ready) latches all issue fields, clears rs1/rs2/rs3 to 0, and sets rd_idx=0, cap_idx=0. Next state is DISPATCH if issue_nsrc==0, else READ.
- READ: rf_rd_en=1, rf_rd_warp=latched warp, rf_rd_reg=src[rd_idx]. rd_idx increments each cycle. After the read with rd_idx==nsrc-1, the state moves to DRAIN.
- Capture: in any cycle following a cycle with rf_rd_en=1, rf_rd_data is written to operand[cap_idx], then cap_idx increments. Data is captured in READ (from the 2nd cycle on) and in DRAIN.
- DRAIN: no read. The last operand is captured. Next state is DISPATCH.
- DISPATCH: alu_valid=1. All alu_* outputs are held stable until alu_ready=1. On the handshake, the state returns to IDLE.
- Operands beyond nsrc remain 0. The ALU relies on this (e.g. MOV computes rs1|imm).
- rf_rd_data is ignored in every cycle not preceded by rf_rd_en=1.
- issue_valid is ignored outside IDLE. No overlap: a new instruction is accepted only in IDLE.
- rf_rd_en is 0 in IDLE, DRAIN and DISPATCH.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE; issue_ready=1; busy=0; alu_valid=0; rf_rd_en=0. rf_rd_warp, rf_rd_reg, alu_op, alu_warp, alu_imm, alu_rs*, alu_src_pred and all internal counters reset to 0.
- Reset mid-operation drops the in-flight instruction. No alu_valid is produced for it.
- Latency, with issue handshake at cycle 0:
  - nsrc=N (1..3): reads in cycles 1..N; DRAIN in cycle N+1; alu_valid first high in cycle N+2.
  - nsrc=0: alu_valid high in cycle 1.
- Best-case throughput with alu_ready tied high: one instruction per N+3 cycles (nsrc=0: one per 2).
- alu_valid never deasserts without a handshake. alu_* outputs do not change while alu_valid=1.
- No combinational path from alu_ready or issue_valid to any output. issue_ready is a function of state only.

## Test plan
- nsrc=3; src=(4,7,9); RF returns lane-l values 100+l, 200+l, 300+l. Expected: rf_rd_reg sequence 4,7,9 in cycles 1–3; alu_valid in cycle 5; alu_rs1[l]=100+l, alu_rs2[l]=200+l, alu_rs3[l]=300+l.
- nsrc=0; op=TID, imm=0x55. Expected: no rf_rd_en; alu_valid in cycle 1; alu_rs1/2/3 all 0; alu_imm=0x55.
- nsrc=1 after an nsrc=3 instruction. Expected: alu_rs2 and alu_rs3 are 0, not stale; alu_valid in cycle 3.
- Backpressure: alu_ready=0 for 6 cycles in DISPATCH, with rf_rd_data and issue_valid toggling randomly. Expected: alu_* stable, issue_ready=0, single handshake when alu_ready rises, then IDLE.
- Assert rst_n=0 during the 2nd READ cycle of an nsrc=3 instruction. Expected: all outputs at reset values immediately; no alu_valid afterwards. A new nsrc=2 issue completes normally with alu_valid in cycle 4.
- Back-to-back issue_valid held high with alu_ready=1, for 3 instructions with nsrc=2. Expected: accept cycles spaced 5 apart; each bundle carries its own op/warp/pred.

Source files
------------

// File: rtl/simt_operand_collector_if.sv
// Signal bundle between warp issue, the vector register file read port and the ALU stage.
// The slave modport is the collector's view; master is the surrounding pipeline.
interface simt_operand_collector_if #(
  parameter int WARP_SIZE = 32,
  parameter int REG_W     = 5
);
  logic                       issue_valid;
  logic                       issue_ready;
  logic [7:0]                 issue_op;
  logic [4:0]                 issue_warp;
  logic [31:0]                issue_imm;
  logic [REG_W-1:0]           issue_src1;
  logic [REG_W-1:0]           issue_src2;
  logic [REG_W-1:0]           issue_src3;
  logic [1:0]                 issue_nsrc;
  logic [WARP_SIZE-1:0]       issue_pred;

  logic                       rf_rd_en;
  logic [4:0]                 rf_rd_warp;
  logic [REG_W-1:0]           rf_rd_reg;
  logic [WARP_SIZE-1:0][31:0] rf_rd_data;

  logic                       alu_valid;
  logic                       alu_ready;
  logic [7:0]                 alu_op;
  logic [4:0]                 alu_warp;
  logic [31:0]                alu_imm;
  logic [WARP_SIZE-1:0][31:0] alu_rs1;
  logic [WARP_SIZE-1:0][31:0] alu_rs2;
  logic [WARP_SIZE-1:0][31:0] alu_rs3;
  logic [WARP_SIZE-1:0]       alu_src_pred;
  logic                       busy;

  modport slave (
    input  issue_valid, issue_op, issue_warp, issue_imm,
           issue_src1, issue_src2, issue_src3, issue_nsrc, issue_pred,
           rf_rd_data, alu_ready,
    output issue_ready, rf_rd_en, rf_rd_warp, rf_rd_reg,
           alu_valid, alu_op, alu_warp, alu_imm,
           alu_rs1, alu_rs2, alu_rs3, alu_src_pred, busy
  );

  modport master (
    output issue_valid, issue_op, issue_warp, issue_imm,
           issue_src1, issue_src2, issue_src3, issue_nsrc, issue_pred,
           rf_rd_data, alu_ready,
    input  issue_ready, rf_rd_en, rf_rd_warp, rf_rd_reg,
           alu_valid, alu_op, alu_warp, alu_imm,
           alu_rs1, alu_rs2, alu_rs3, alu_src_pred, busy
  );
endinterface

// File: rtl/simt_operand_collector.sv
// Sequential operand collector: reads up to three source vectors through a single
// one-cycle-latency RF port, then holds the full bundle for the ALU under valid/ready.
module simt_operand_collector #(
  parameter int WARP_SIZE = 32,
  parameter int REG_W     = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  simt_operand_collector_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DISPATCH} state_e;

  state_e                     state_q, state_d;
  logic [7:0]                 op_q;
  logic [4:0]                 warp_q;
  logic [31:0]                imm_q;
  logic [REG_W-1:0]           src1_q, src2_q, src3_q;
  logic [1:0]                 nsrc_q;
  logic [WARP_SIZE-1:0]       pred_q;
  logic [WARP_SIZE-1:0][31:0] rs1_q, rs2_q, rs3_q;
  logic [1:0]                 rd_idx_q, cap_idx_q;
  logic                       cap_en_q;

  logic                       issue_fire;
  logic                       rd_en;
  logic                       last_read;
  logic [REG_W-1:0]           rd_reg;

  assign issue_fire = (state_q == IDLE) && bus.issue_valid;
  assign rd_en      = (state_q == READ);
  assign last_read  = (rd_idx_q == nsrc_q - 2'd1);

  // NOTE: every variable written in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    rd_reg = '0;
    case (rd_idx_q)
      2'd0:    rd_reg = src1_q;
      2'd1:    rd_reg = src2_q;
      default: rd_reg = src3_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (bus.issue_valid) state_d = (bus.issue_nsrc == 2'd0) ? DISPATCH : READ;
      READ:     if (last_read) state_d = DRAIN;
      DRAIN:    state_d = DISPATCH;
      DISPATCH: if (bus.alu_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the operand vectors are flops, not RAM, and are reset so the ALU sees zeros after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      warp_q    <= '0;
      imm_q     <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      src3_q    <= '0;
      nsrc_q    <= '0;
      pred_q    <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs3_q     <= '0;
      rd_idx_q  <= '0;
      cap_idx_q <= '0;
      cap_en_q  <= 1'b0;
    end else begin
      // Read data returns one cycle after the strobe, so capture lags the read by one cycle.
      cap_en_q <= rd_en;
      if (issue_fire) begin
        op_q      <= bus.issue_op;
        warp_q    <= bus.issue_warp;
        imm_q     <= bus.issue_imm;
        src1_q    <= bus.issue_src1;
        src2_q    <= bus.issue_src2;
        src3_q    <= bus.issue_src3;
        nsrc_q    <= bus.issue_nsrc;
        pred_q    <= bus.issue_pred;
        rs1_q     <= '0;
        rs2_q     <= '0;
        rs3_q     <= '0;
        rd_idx_q  <= '0;
        cap_idx_q <= '0;
      end
      if (rd_en) rd_idx_q <= rd_idx_q + 2'd1;
      if (cap_en_q) begin
        case (cap_idx_q)
          2'd0:    rs1_q <= bus.rf_rd_data;
          2'd1:    rs2_q <= bus.rf_rd_data;
          default: rs3_q <= bus.rf_rd_data;
        endcase
        cap_idx_q <= cap_idx_q + 2'd1;
      end
    end
  end

  assign bus.issue_ready  = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.rf_rd_en     = rd_en;
  assign bus.rf_rd_warp   = rd_en ? warp_q : '0;
  assign bus.rf_rd_reg    = rd_en ? rd_reg : '0;
  assign bus.alu_valid    = (state_q == DISPATCH);
  assign bus.alu_op       = op_q;
  assign bus.alu_warp     = warp_q;
  assign bus.alu_imm      = imm_q;
  assign bus.alu_rs1      = rs1_q;
  assign bus.alu_rs2      = rs2_q;
  assign bus.alu_rs3      = rs3_q;
  assign bus.alu_src_pred = pred_q;

endmodule

// File: tb/tb_simt_operand_collector.sv
// Self-checking bench for simt_operand_collector: directed scenarios plus randomized
// instructions against a register-file model that computes expected operand bundles.
module tb_simt_operand_collector;
  localparam int WARP_SIZE = 32;
  localparam int REG_W     = 5;
  localparam logic [7:0] OP_TID = 8'h21;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;

  // RF model: lane l of register r in warp w holds rf_base[r] + l + (w << 20).
  logic [31:0]      rf_base [32];
  logic             prev_en;
  logic [4:0]       prev_warp;
  logic [REG_W-1:0] prev_reg;

  simt_operand_collector_if #(.WARP_SIZE(WARP_SIZE), .REG_W(REG_W)) bus ();

  simt_operand_collector #(.WARP_SIZE(WARP_SIZE), .REG_W(REG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rf_val(input logic [4:0] w, input logic [REG_W-1:0] r,
                                         input int lane);
    return rf_base[r] + 32'(lane) + {7'd0, w, 20'd0};
  endfunction

  // Advance to the next negedge; return RF data for a read strobed in the previous cycle,
  // junk otherwise.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int l = 0; l < WARP_SIZE; l++)
      bus.rf_rd_data[l] = prev_en ? rf_val(prev_warp, prev_reg, l) : $urandom;
    prev_en   = bus.rf_rd_en;
    prev_warp = bus.rf_rd_warp;
    prev_reg  = bus.rf_rd_reg;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".issue_ready"}, 64'(bus.issue_ready), 64'd1);
    check({tag, ".busy"},        64'(bus.busy),        64'd0);
    check({tag, ".alu_valid"},   64'(bus.alu_valid),   64'd0);
    check({tag, ".rf_rd_en"},    64'(bus.rf_rd_en),    64'd0);
    check({tag, ".rf_rd_warp"},  64'(bus.rf_rd_warp),  64'd0);
    check({tag, ".rf_rd_reg"},   64'(bus.rf_rd_reg),   64'd0);
    check({tag, ".alu_op"},      64'(bus.alu_op),      64'd0);
    check({tag, ".alu_warp"},    64'(bus.alu_warp),    64'd0);
    check({tag, ".alu_imm"},     64'(bus.alu_imm),     64'd0);
    check({tag, ".alu_pred"},    64'(bus.alu_src_pred), 64'd0);
    check({tag, ".alu_rs_any"},  64'(|{bus.alu_rs1, bus.alu_rs2, bus.alu_rs3}), 64'd0);
  endtask

  task automatic check_bundle(input logic [7:0] op, input logic [4:0] warp, input logic [31:0] imm,
                              input logic [WARP_SIZE-1:0] pred, input logic [REG_W-1:0] s1,
                              input logic [REG_W-1:0] s2, input logic [REG_W-1:0] s3,
                              input logic [1:0] nsrc);
    logic [REG_W-1:0] src [3];
    logic [31:0]      obs, exp;
    src[0] = s1; src[1] = s2; src[2] = s3;
    check("alu_op",   64'(bus.alu_op),       64'(op));
    check("alu_warp", 64'(bus.alu_warp),     64'(warp));
    check("alu_imm",  64'(bus.alu_imm),      64'(imm));
    check("alu_pred", 64'(bus.alu_src_pred), 64'(pred));
    for (int j = 0; j < 3; j++) begin
      for (int l = 0; l < WARP_SIZE; l++) begin
        obs = (j == 0) ? bus.alu_rs1[l] : (j == 1) ? bus.alu_rs2[l] : bus.alu_rs3[l];
        exp = (j < int'(nsrc)) ? rf_val(warp, src[j], l) : 32'd0;
        check($sformatf("alu_rs%0d[%0d]", j + 1, l), 64'(obs), 64'(exp));
      end
    end
  endtask

  // Issue one instruction at the current negedge and follow it through to the ALU handshake.
  // Returns at the negedge of the first IDLE cycle after the handshake.
  task automatic run_instr(input logic [7:0] op, input logic [4:0] warp, input logic [31:0] imm,
                           input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2,
                           input logic [REG_W-1:0] s3, input logic [1:0] nsrc,
                           input logic [WARP_SIZE-1:0] pred, input int stall,
                           input bit keep_valid, output int acc_cyc);
    int guard = 0;
    int lat;
    logic [REG_W-1:0] src [3];
    src[0] = s1; src[1] = s2; src[2] = s3;
    while (bus.issue_ready !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    check("issue_ready_idle", 64'(bus.issue_ready), 64'd1);
    bus.issue_op = op;   bus.issue_warp = warp; bus.issue_imm = imm;
    bus.issue_src1 = s1; bus.issue_src2 = s2;   bus.issue_src3 = s3;
    bus.issue_nsrc = nsrc; bus.issue_pred = pred;
    bus.issue_valid = 1'b1;
    bus.alu_ready   = 1'($urandom_range(0, 1));
    acc_cyc = cyc;
    lat = (nsrc == 2'd0) ? 1 : int'(nsrc) + 2;
    for (int k = 1; k <= lat + stall; k++) begin
      step();
      if (!keep_valid) begin
        bus.issue_valid = 1'($urandom_range(0, 1));
        bus.issue_op    = 8'($urandom);
        bus.issue_warp  = 5'($urandom);
        bus.issue_imm   = $urandom;
        bus.issue_src1  = REG_W'($urandom);
        bus.issue_nsrc  = 2'($urandom);
        bus.issue_pred  = $urandom;
      end
      check("rf_rd_en", 64'(bus.rf_rd_en), 64'(k <= int'(nsrc)));
      if (k <= int'(nsrc)) begin
        check("rf_rd_reg",  64'(bus.rf_rd_reg),  64'(src[k-1]));
        check("rf_rd_warp", 64'(bus.rf_rd_warp), 64'(warp));
      end
      check("busy",        64'(bus.busy),        64'd1);
      check("issue_ready", 64'(bus.issue_ready), 64'd0);
      check("alu_valid",   64'(bus.alu_valid),   64'(k >= lat));
      if (k >= lat) check_bundle(op, warp, imm, pred, s1, s2, s3, nsrc);
      bus.alu_ready = (k < lat) ? 1'($urandom_range(0, 1)) : 1'(k == lat + stall);
    end
    step();
    bus.alu_ready   = 1'b0;
    bus.issue_valid = keep_valid;
    check("post_hs_alu_valid",   64'(bus.alu_valid),   64'd0);
    check("post_hs_issue_ready", 64'(bus.issue_ready), 64'd1);
    check("post_hs_busy",        64'(bus.busy),        64'd0);
  endtask

  initial begin
    int acc;
    int acc_b2b [3];
    for (int r = 0; r < 32; r++) rf_base[r] = $urandom;
    prev_en = 1'b0; prev_warp = '0; prev_reg = '0;
    bus.issue_valid = 1'b0; bus.issue_op = '0; bus.issue_warp = '0; bus.issue_imm = '0;
    bus.issue_src1 = '0; bus.issue_src2 = '0; bus.issue_src3 = '0; bus.issue_nsrc = '0;
    bus.issue_pred = '0; bus.rf_rd_data = '0; bus.alu_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    step();
    check_reset_vals("after_reset");

    // Three sources, RF lanes 100+l / 200+l / 300+l.
    rf_base[4] = 32'd100; rf_base[7] = 32'd200; rf_base[9] = 32'd300;
    run_instr(8'h10, 5'd0, 32'h0, 5'd4, 5'd7, 5'd9, 2'd3, 32'hDEAD_BEEF, 0, 1'b0, acc);

    // No sources: bundle straight to dispatch with zero operands.
    run_instr(OP_TID, 5'd3, 32'h55, 5'd1, 5'd2, 5'd3, 2'd0, 32'h0F0F_0F0F, 0, 1'b0, acc);

    // nsrc=1 right after nsrc=3: rs2/rs3 must be zero, not stale.
    run_instr(8'h11, 5'd6, 32'h1234, 5'd11, 5'd12, 5'd13, 2'd3, 32'h1, 0, 1'b0, acc);
    run_instr(8'h12, 5'd6, 32'h5678, 5'd14, 5'd12, 5'd13, 2'd1, 32'h2, 0, 1'b0, acc);

    // Six cycles of ALU backpressure with junk on the issue port and RF data.
    run_instr(8'h13, 5'd9, 32'hCAFE, 5'd20, 5'd21, 5'd0, 2'd2, 32'hA5A5_5A5A, 6, 1'b0, acc);

    // Reset during the second read cycle of an nsrc=3 instruction.
    bus.issue_op = 8'h44; bus.issue_warp = 5'd12; bus.issue_imm = 32'h77;
    bus.issue_src1 = 5'd1; bus.issue_src2 = 5'd2; bus.issue_src3 = 5'd3;
    bus.issue_nsrc = 2'd3; bus.issue_pred = 32'hFFFF_FFFF; bus.issue_valid = 1'b1;
    step();
    bus.issue_valid = 1'b0;
    step();
    check("mid_rst_pre_rd_en", 64'(bus.rf_rd_en), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("post_rst_alu_valid", 64'(bus.alu_valid), 64'd0);
      check("post_rst_ready",     64'(bus.issue_ready), 64'd1);
    end
    run_instr(8'h45, 5'd13, 32'h99, 5'd30, 5'd31, 5'd0, 2'd2, 32'h8000_0001, 0, 1'b0, acc);

    // Back-to-back with issue_valid held high: accepts spaced nsrc+3 = 5 apart.
    for (int i = 0; i < 3; i++)
      run_instr(8'h30 + 8'(i), 5'(i + 1), 32'(i * 3), 5'(2 * i), 5'(2 * i + 1), 5'd0, 2'd2,
                32'h1 << i, 0, 1'b1, acc_b2b[i]);
    bus.issue_valid = 1'b0;
    check("b2b_gap0", 64'(acc_b2b[1] - acc_b2b[0]), 64'd5);
    check("b2b_gap1", 64'(acc_b2b[2] - acc_b2b[1]), 64'd5);

    // Randomized instructions with random RF contents, gaps and backpressure.
    for (int n = 0; n < 40; n++) begin
      for (int r = 0; r < 32; r++) rf_base[r] = $urandom;
      repeat ($urandom_range(0, 2)) step();
      run_instr(8'($urandom), 5'($urandom), $urandom, REG_W'($urandom), REG_W'($urandom),
                REG_W'($urandom), 2'($urandom), $urandom, int'($urandom_range(0, 4)), 1'b0, acc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
